pipe_latch_buf: RTL and testbench

- Parametrised successor to the fixed fetch/dispatch, issue/execute and execute/writeback latches.
- A DEPTH-entry elastic latch carrying any packed stage struct (fd_t, ie_t, ew_t, cast to DATA_W bits) between two pipeline stages.
- Uses a valid/ready handshake, synchronous flush and registered outputs.
- Lets stages decouple under stalls (e.g. a multi-cycle gemm or mls unit) without a global freeze.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/pipe_latch_buf_ptr.sv | 33 +++
 rtl/pipe_latch_buf.sv | 142 ++++++++++++++
 tb/tb_pipe_latch_buf.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared pipeline definitions used by the inter-stage latch buffers.
//   PIPE_BUF_MAX_DEPTH : largest legal DEPTH of a pipe_latch_buf instance.
//   pipe_buf_stats_t   : occupancy/flow statistics counters, used when the
//                        latch is built with PIPE_LATCH_BUF_STATS_EN.
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int PIPE_BUF_MAX_DEPTH = 16;

    typedef struct packed {
        logic [31:0] stall_cycles;
        logic [31:0] bubble_cycles;
        logic [15:0] flush_count;
    } pipe_buf_stats_t;

endpackage

// File: rtl/pipe_latch_buf_ptr.sv
// -----------------------------------------------------------------------------
// pipe_latch_buf_ptr
// Modulo-DEPTH pointer with wrap from DEPTH-1 back to 0; works for any depth,
// including non-power-of-two.
// Ports:
//   CLK   in   clock, rising edge
//   nRST  in   asynchronous active-low reset (pointer -> 0)
//   clr   in   synchronous clear to 0, dominates inc
//   inc   in   advance pointer by one (with wrap)
//   ptr   out  current pointer value
// -----------------------------------------------------------------------------
module pipe_latch_buf_ptr #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/pipe_latch_buf.sv
// -----------------------------------------------------------------------------
// pipe_latch_buf
// DEPTH-entry elastic latch between two pipeline stages. Carries any packed
// stage struct cast to DATA_W bits, with a valid/ready handshake on both
// sides, synchronous flush and outputs decoded from registered state only.
// Optional statistics counters are built when PIPE_LATCH_BUF_STATS_EN is
// defined.
// Ports:
//   CLK, nRST            clock (rising edge), async active-low reset
//   flush                synchronous kill of all stored entries
//   in_valid/in_ready    upstream handshake, in_data sampled on push
//   out_valid/out_ready  downstream handshake, out_data is the oldest entry
//   count, full, empty   occupancy status
//   stall_cycles, bubble_cycles, flush_count  (PIPE_LATCH_BUF_STATS_EN only)
// -----------------------------------------------------------------------------
module pipe_latch_buf
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
`ifdef PIPE_LATCH_BUF_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       bubble_cycles,
    output logic [15:0]       flush_count
`endif
);

    // A single-entry latch still uses a 1-bit pointer; its second memory
    // slot is never addressed.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MEM_N = (DEPTH > 1) ? DEPTH : 2;

    if (DEPTH < 1 || DEPTH > PIPE_BUF_MAX_DEPTH) begin : g_depth_check
        $error("pipe_latch_buf: DEPTH out of range");
    end

    logic [DATA_W-1:0] mem [MEM_N];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic              rd_en;

    // Status is decoded from the count register alone, so in_ready never
    // depends combinationally on out_ready.
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];

    assign push  = in_valid & in_ready;
    assign pop   = out_valid & out_ready;
    assign wr_en = push & !flush;
    assign rd_en = pop & !flush;

    pipe_latch_buf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .CLK  (CLK),
        .nRST (nRST),
        .clr  (flush),
        .inc  (wr_en),
        .ptr  (wr_ptr)
    );

    pipe_latch_buf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .CLK  (CLK),
        .nRST (nRST),
        .clr  (flush),
        .inc  (rd_en),
        .ptr  (rd_ptr)
    );

    // Storage: payload only, not reset
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Occupancy
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (wr_en && !rd_en) begin
            count <= count + CNT_W'(1);
        end else if (rd_en && !wr_en) begin
            count <= count - CNT_W'(1);
        end
    end

`ifdef PIPE_LATCH_BUF_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    pipe_buf_stats_t stats;

    // Statistics survive flush; only nRST clears them
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stats <= '0;
        end else begin
            if (in_valid && !in_ready) begin
                stats.stall_cycles <= sat_inc32(stats.stall_cycles);
            end
            if (out_ready && !out_valid) begin
                stats.bubble_cycles <= sat_inc32(stats.bubble_cycles);
            end
            if (flush) begin
                stats.flush_count <= sat_inc16(stats.flush_count);
            end
        end
    end

    assign stall_cycles  = stats.stall_cycles;
    assign bubble_cycles = stats.bubble_cycles;
    assign flush_count   = stats.flush_count;
`endif

endmodule

// File: tb/tb_pipe_latch_buf.sv
module tb_pipe_latch_buf;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    // DEPTH=2 instance
    logic        f2 = 0, v2 = 0, r2 = 0;
    logic [31:0] di2 = 0;
    logic        ir2, ov2, full2, empty2;
    logic [31:0] od2;
    logic [1:0]  cnt2;

    // DEPTH=3 instance
    logic        f3 = 0, v3 = 0, r3 = 0;
    logic [31:0] di3 = 0;
    logic        ir3, ov3, full3, empty3;
    logic [31:0] od3;
    logic [1:0]  cnt3;

    // DEPTH=1 instance
    logic        f1 = 0, v1 = 0, r1 = 0;
    logic [31:0] di1 = 0;
    logic        ir1, ov1, full1, empty1;
    logic [31:0] od1;
    logic [0:0]  cnt1;
`ifdef PIPE_LATCH_BUF_STATS_EN
    logic [31:0] stall1, bubble1;
    logic [15:0] fcnt1;
`endif

    pipe_latch_buf #(.DATA_W(32), .DEPTH(2)) u_d2 (
        .CLK(CLK), .nRST(nRST), .flush(f2), .in_valid(v2), .in_ready(ir2),
        .in_data(di2), .out_valid(ov2), .out_ready(r2), .out_data(od2),
        .count(cnt2), .full(full2), .empty(empty2)
    );

    pipe_latch_buf #(.DATA_W(32), .DEPTH(3)) u_d3 (
        .CLK(CLK), .nRST(nRST), .flush(f3), .in_valid(v3), .in_ready(ir3),
        .in_data(di3), .out_valid(ov3), .out_ready(r3), .out_data(od3),
        .count(cnt3), .full(full3), .empty(empty3)
    );

    pipe_latch_buf #(.DATA_W(32), .DEPTH(1)) u_d1 (
        .CLK(CLK), .nRST(nRST), .flush(f1), .in_valid(v1), .in_ready(ir1),
        .in_data(di1), .out_valid(ov1), .out_ready(r1), .out_data(od1),
        .count(cnt1), .full(full1), .empty(empty1)
`ifdef PIPE_LATCH_BUF_STATS_EN
        , .stall_cycles(stall1), .bubble_cycles(bubble1), .flush_count(fcnt1)
`endif
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int  sent, rcvd, mcnt;
    logic p_push, p_pop;

    initial begin
        // Reset then idle
        tick();
        tick();
        chk("rst_out_valid", 32'(ov2), 0);
        chk("rst_empty", 32'(empty2), 1);
        chk("rst_in_ready", 32'(ir2), 1);
        chk("rst_count", 32'(cnt2), 0);
        chk("rst_full", 32'(full2), 0);
        chk("rst_out_data", od2, 0);
        chk("rst_d3_empty", 32'(empty3), 1);
        chk("rst_d1_in_ready", 32'(ir1), 1);
        nRST = 1'b1;
        tick();
        chk("idle_count", 32'(cnt2), 0);
        chk("idle_empty", 32'(empty2), 1);

        // Streaming DEPTH=2, out_ready=1
        r2 = 1; v2 = 1; di2 = 32'h11;
        tick();
        chk("strm_data0", od2, 32'h11);
        chk("strm_valid0", 32'(ov2), 1);
        chk("strm_count0", 32'(cnt2), 1);
        chk("strm_ready0", 32'(ir2), 1);
        di2 = 32'h22;
        tick();
        chk("strm_data1", od2, 32'h22);
        chk("strm_count1", 32'(cnt2), 1);
        chk("strm_ready1", 32'(ir2), 1);
        di2 = 32'h33;
        tick();
        chk("strm_data2", od2, 32'h33);
        chk("strm_count2", 32'(cnt2), 1);
        v2 = 0;
        tick();
        chk("strm_drain_empty", 32'(empty2), 1);
        chk("strm_drain_valid", 32'(ov2), 0);

        // Backpressure fill DEPTH=2
        r2 = 0; v2 = 1; di2 = 32'hA;
        tick();
        chk("bp_count1", 32'(cnt2), 1);
        chk("bp_data_a", od2, 32'hA);
        di2 = 32'hB;
        tick();
        chk("bp_full", 32'(full2), 1);
        chk("bp_in_ready", 32'(ir2), 0);
        chk("bp_count2", 32'(cnt2), 2);
        di2 = 32'hC;
        tick();
        chk("bp_refused_count", 32'(cnt2), 2);
        chk("bp_hold_data", od2, 32'hA);
        r2 = 1;
        tick();
        chk("bp_pop_only_count", 32'(cnt2), 1);
        chk("bp_data_b", od2, 32'hB);
        tick();
        chk("bp_data_c", od2, 32'hC);
        chk("bp_count_c", 32'(cnt2), 1);
        v2 = 0;
        tick();
        chk("bp_drained", 32'(empty2), 1);

        // Flush priority with full latch
        r2 = 0; v2 = 1; di2 = 32'h1;
        tick();
        di2 = 32'h2;
        tick();
        chk("fl_pre_count", 32'(cnt2), 2);
        f2 = 1; di2 = 32'h55; r2 = 1;
        tick();
        chk("fl_count", 32'(cnt2), 0);
        chk("fl_valid", 32'(ov2), 0);
        chk("fl_in_ready", 32'(ir2), 1);
        f2 = 0; v2 = 0;
        tick();
        chk("fl_no_55", 32'(ov2), 0);
        // Flush discards a same-cycle push that would otherwise be accepted
        r2 = 0; v2 = 1; di2 = 32'h66;
        tick();
        f2 = 1; di2 = 32'h77;
        tick();
        chk("fl_push_discard", 32'(cnt2), 0);
        f2 = 0; di2 = 32'h88; r2 = 1;
        tick();
        chk("fl_after_data", od2, 32'h88);
        chk("fl_after_count", 32'(cnt2), 1);

        // Wrap-around DEPTH=3 with random out_ready
        sent = 0; rcvd = 0; mcnt = 0;
        for (int cyc = 0; cyc < 300 && rcvd < 10; cyc++) begin
            v3 = (sent < 10);
            di3 = 32'(sent);
            r3 = 1'($urandom_range(0, 1));
            p_push = v3 && ir3;
            p_pop = ov3 && r3;
            if (p_pop) begin
                chk("wrap_data", od3, 32'(rcvd));
                rcvd++;
            end
            tick();
            if (p_push) sent++;
            mcnt = mcnt + (p_push ? 1 : 0) - (p_pop ? 1 : 0);
            chk("wrap_count", 32'(cnt3), 32'(mcnt));
        end
        v3 = 0; r3 = 0;
        chk("wrap_received", 32'(rcvd), 10);

        // DEPTH=1 stall latch: alternate-cycle throughput
        r1 = 1; v1 = 1; di1 = 32'h5A;
        tick();
        chk("d1_full", 32'(full1), 1);
        chk("d1_in_ready", 32'(ir1), 0);
        chk("d1_data0", od1, 32'h5A);
        di1 = 32'h5B;
        tick();
        chk("d1_pop_refuse", 32'(cnt1), 0);
        chk("d1_ready_again", 32'(ir1), 1);
        tick();
        chk("d1_data1", od1, 32'h5B);
        v1 = 0;
        tick();
        chk("d1_drained", 32'(empty1), 1);

        // Async reset in the middle of a transfer (d2 holds 0x88)
        v2 = 0; r2 = 0;
        chk("ar_pre_count", 32'(cnt2), 1);
        nRST = 1'b0;
        #2;
        chk("ar_count", 32'(cnt2), 0);
        chk("ar_valid", 32'(ov2), 0);
        chk("ar_empty", 32'(empty2), 1);
        r1 = 0;
        tick();
        nRST = 1'b1;
        tick();
        chk("ar_after_empty", 32'(empty2), 1);

`ifdef PIPE_LATCH_BUF_STATS_EN
        chk("st_rst_stall", stall1, 0);
        chk("st_rst_flush", 32'(fcnt1), 0);
        v1 = 1; di1 = 32'h9;
        tick();
        for (int i = 0; i < 5; i++) tick();
        v1 = 0; f1 = 1;
        tick();
        tick();
        f1 = 0;
        tick();
        chk("st_stall", stall1, 5);
        chk("st_flush", 32'(fcnt1), 2);
        chk("st_bubble0", bubble1, 0);
        chk("st_flushed_empty", 32'(empty1), 1);
        r1 = 1;
        tick();
        tick();
        tick();
        chk("st_bubble3", bubble1, 3);
        chk("st_stall_kept", stall1, 5);
        r1 = 0;
        nRST = 1'b0;
        #2;
        chk("st_clr_stall", stall1, 0);
        chk("st_clr_flush", 32'(fcnt1), 0);
        chk("st_clr_bubble", bubble1, 0);
        tick();
        nRST = 1'b1;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
